// File: rtl/seq_detector_0110_moore_if.sv
// rtl/seq_detector_0110_moore_if.sv - serial bit in / detect flag out bundle for the 0110 detector
interface seq_detector_0110_moore_if;
  logic x;
  logic z;

  modport master (output x, input z);
  modport slave  (input x, output z);
endinterface

// File: rtl/seq_detector_0110_moore.sv
// rtl/seq_detector_0110_moore.sv - overlapping Moore detector for serial pattern 0110
module seq_detector_0110_moore (
  input  logic                          clk,
  input  logic                          reset,
  seq_detector_0110_moore_if.slave      bus
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // S4 re-enters the pattern as if its trailing 0 were a fresh leading 0
  always_comb begin
    state_next = S0;
    case (state)
      S0: state_next = bus.x ? S0 : S1;
      S1: state_next = bus.x ? S2 : S1;
      S2: state_next = bus.x ? S3 : S1;
      S3: state_next = bus.x ? S0 : S4;
      S4: state_next = bus.x ? S2 : S1;
      default: state_next = S0;
    endcase
  end

  assign bus.z = (state == S4);

endmodule

// File: tb/tb_seq_detector_0110_moore.sv
// tb/tb_seq_detector_0110_moore.sv - scoreboard bench for the 0110 Moore detector
module tb_seq_detector_0110_moore;

  logic clk;
  logic reset;

  seq_detector_0110_moore_if bus ();

  seq_detector_0110_moore dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic exp_q[$];
  int   vec_q[$];
  int   n_checked;
  int   n_fail;
  int   n_issued;

  // Monitor: every posedge produces one z value; sample it 1ns after the edge
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      logic e;
      int   v;
      e = exp_q.pop_front();
      v = vec_q.pop_front();
      n_checked++;
      if (bus.z !== e) begin
        n_fail++;
        $display("FAIL vec%0d z: got %b, expected %b", v, bus.z, e);
      end
    end
  end

  // Drive one bit at the negedge so it is stable for the next posedge
  task automatic apply(input logic r, input logic xi, input logic ez, input logic glitch);
    @(negedge clk);
    reset = r;
    bus.x = xi;
    exp_q.push_back(ez);
    vec_q.push_back(n_issued);
    n_issued++;
    if (glitch) begin
      #1 reset = 1'b1;
      #1 reset = 1'b0;
    end
  endtask

  task automatic bit_in(input logic xi, input logic ez);
    apply(1'b0, xi, ez, 1'b0);
  endtask

  initial begin
    n_checked = 0;
    n_fail    = 0;
    n_issued  = 0;
    reset     = 1'b1;
    bus.x     = 1'b0;

    // reset sanity with x toggling
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    bit_in(1'b1, 1'b0);

    // basic match 0,0,1,0,1,1,0
    bit_in(1'b0, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b1);

    // overlap 1,1,0 then 0,0
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b1);
    bit_in(1'b0, 1'b0);
    bit_in(1'b0, 1'b0);

    // reset, then basic match with a reset glitch between edges
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b1);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b1);
    bit_in(1'b0, 1'b1);

    // near miss 0,1,1,1,0
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);

    // 0,1,0,1,1,0 continuing from S1
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b1);

    // reset mid-pattern: 0,1,1 then reset with x=0, then 0,1,1,0
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b1);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    if (n_checked != n_issued) begin
      n_fail++;
      $display("FAIL count: checked %0d, expected %0d", n_checked, n_issued);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checked, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_0110_moore.md
Name: seq_detector_0110_moore

Overview:
Serial-bit pattern detector that watches a 1-bit input stream, sampled once per rising clock edge, for the sequence 0-1-1-0 (first bit oldest).
Moore FSM: output z is a decoded function of the registered state only, never of the current input.
Detection is overlapping: the final 0 of a match also counts as the first 0 of the next candidate.
Used as a small control-path pattern-recognition block; z is a single-cycle flag to downstream logic.

Parameters:
none (fixed pattern 0110, fixed 1-bit input).

Ports:
clk    input   1  rising-edge clock; all state changes on posedge clk
reset  input   1  synchronous, active-high reset, sampled only at posedge clk
x      input   1  serial data bit, sampled at posedge clk
z      output  1  detection flag; 1 for exactly one cycle after 0110 is received

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - reset=1 at a posedge forces state S0 and z=0 on that edge.
  - reset has priority over x.
  - A reset pulse that does not cover a rising edge has no effect.
- States (3-bit state register; encoding free, must be one of these five):
  - S0 = nothing matched
  - S1 = "0"
  - S2 = "01"
  - S3 = "011"
  - S4 = "0110" matched
- Transitions at posedge clk (current state, x -> next state):
  - S0: 0->S1, 1->S0
  - S1: 0->S1, 1->S2
  - S2: 0->S1, 1->S3
  - S3: 0->S4, 1->S0
  - S4: 0->S1, 1->S2 (overlap: the trailing 0 acts as a new leading 0)
- Output:
  - z = 1 iff state == S4, otherwise z = 0.
  - z is decoded from the state register only; x changing mid-cycle never glitches z.
- Latency:
  - z rises on the same posedge that samples the final 0 of the pattern.
  - z stays high for exactly one clock period.
  - Back-to-back overlapping matches (e.g. 0110110) give z pulses 3 cycles apart.
- Illegal or unused state encodings go to S0 on the next edge with z=0.
- No enable and no handshake; every clock edge consumes one bit.

Test Plan:
1. Reset sanity: hold reset=1 for 2 edges with x toggling -> z=0, state S0; release -> z stays 0 until a full 0110 is seen.
2. Basic match: after reset, drive x = 0,0,1,0,1,1,0 on successive edges -> z=0 through the 6th edge, z=1 after the 7th edge for exactly one cycle.
3. Overlap and restart:
   - Continue the sequence from scenario 2 with x = 1,1,0 -> z=1 after the 3rd bit (the prior 0 reused).
   - Then drive x = 0,0 -> z returns to 0 and stays 0.
4. Non-edge reset glitch: during scenario 2, pulse reset high for 1ns between two rising edges -> no effect; detection completes as in scenario 2.
5. Near misses:
   - x = 0,1,1,1,0 -> z never asserts (S3 on 1 returns to S0).
   - x = 0,1,0,1,1,0 -> z=1 only after the final 0.
6. Reset mid-pattern: after x = 0,1,1, assert reset on the next edge with x=0 -> z stays 0, state S0; a subsequent 0,1,1,0 -> z=1.
